axi2core: RTL and testbench
===========================

AXI2CORE -- requirements
Module: axi2core

Interface
REQ-001 SHALL have parameter AXI4_ADDRESS_WIDTH, default 32, giving the AXI and memory address width.
REQ-002 SHALL have parameter AXI4_ID_WIDTH, default 16, giving the AXI ID width.
REQ-003 SHALL have parameter AXI4_USER_WIDTH, default 10, giving the AXI user width; user inputs are ignored and user outputs are driven 0.
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk_i in 1 (all state on rising edge); rst_i in 1 (async assert, active-high).
REQ-005 SHALL have AXI slave AW channel: aw_id_i in ID, aw_addr_i in ADDR, aw_len_i in 8, aw_size_i in 3, aw_burst_i in 2, aw_user_i in USER, aw_valid_i in 1, aw_ready_o out 1.
REQ-006 SHALL have AXI slave W channel: w_data_i in 32, w_strb_i in 4, w_last_i in 1, w_user_i in USER, w_valid_i in 1, w_ready_o out 1.
REQ-007 SHALL have AXI slave B channel: b_id_o out ID, b_resp_o out 2, b_user_o out USER, b_valid_o out 1, b_ready_i in 1.
REQ-008 SHALL have AXI slave AR channel: ar_id_i in ID, ar_addr_i in ADDR, ar_len_i in 8, ar_size_i in 3, ar_burst_i in 2, ar_user_i in USER, ar_valid_i in 1, ar_ready_o out 1.
REQ-009 SHALL have AXI slave R channel: r_id_o out ID, r_data_o out 32, r_resp_o out 2, r_last_o out 1, r_user_o out USER, r_valid_o out 1, r_ready_i in 1.
REQ-010 SHALL have core-style memory initiator port: mem_req_o out 1, mem_gnt_i in 1, mem_addr_o out ADDR, mem_we_o out 1, mem_be_o out 4, mem_wdata_o out 32, mem_rvalid_i in 1, mem_rdata_i in 32, mem_err_i in 1 (valid with mem_rvalid_i).

Function
REQ-011 SHALL implement FSM states IDLE, WR_DATA, WR_DRAIN, MEM_REQ, MEM_WAIT, B_RESP, R_RESP; one transaction in flight at most.
REQ-012 IDLE: ar_ready_o/aw_ready_o depend only on state, prio bit and the two valids; w_ready_o=0 (W waits for AW).
REQ-013 IDLE arbitration: only ar_valid_i -> ar_ready_o=1; only aw_valid_i -> aw_ready_o=1; both -> grant per prio bit (0=read), never both readies high.
REQ-014 prio SHALL toggle to the other type on every accepted AR or AW handshake.
REQ-015 On AR/AW handshake SHALL register id, addr, len and type (read/write).
REQ-016 AR handshake, len==0 -> MEM_REQ (we=0); len!=0 -> R_RESP error mode, beat counter=0, memory untouched.
REQ-017 AW handshake -> WR_DATA (w_ready_o=1); W handshake captures data/strb; len==0 -> MEM_REQ (we=1); len!=0 -> error flag set, WR_DRAIN if w_last_i=0 else B_RESP.
REQ-018 WR_DRAIN: w_ready_o=1, discard beats; beat with w_last_i=1 -> B_RESP with SLVERR.
REQ-019 MEM_REQ: mem_req_o=1 with addr, we, be, wdata stable (mem_addr_o = registered addr with bits[1:0]=0; mem_be_o=1111 for reads); mem_gnt_i=1 -> MEM_WAIT, mem_req_o low next cycle.
REQ-020 MEM_WAIT: mem_rvalid_i=1 -> register mem_rdata_i and resp (mem_err_i ? SLVERR 2'b10 : OKAY 2'b00); go B_RESP for writes, R_RESP for reads; mem_rvalid_i in any other state SHALL be ignored.
REQ-021 B_RESP: b_valid_o=1, b_id_o=registered id, b_resp_o stable; b_ready_i=1 -> IDLE.
REQ-022 R_RESP normal: r_valid_o=1, r_last_o=1, r_id_o=id, r_data_o=registered rdata; r_ready_i=1 -> IDLE.
REQ-023 R_RESP error mode: ar_len+1 beats, r_resp_o=SLVERR, r_data_o=0, r_last_o=1 only when counter==len; counter increments per r_ready_i handshake; final handshake -> IDLE.
REQ-024 Valid outputs SHALL stay high with stable payload until the handshake (no retraction).
REQ-025 Minimum read latency: AR handshake cycle 0, mem_req_o cycle 1, gnt cycle 1, rvalid cycle 2, r_valid_o cycle 3.
REQ-026 Back-to-back: a new AR/AW SHALL be accepted the cycle after B/R final handshake (IDLE), no extra bubble.

Reset
REQ-027 rst_i SHALL asynchronously force IDLE, prio=0, counter=0, and all valid/ready/req outputs and registered payload outputs to 0.
REQ-028 Reset mid-transaction SHALL abandon it; no B/R response and no mem_req_o after release.

Verification
REQ-029 Read: AR id=5 addr=0x104 len=0; gnt immediate; rvalid rdata=0xDEADBEEF err=0 -> mem_addr_o=0x104, we=0; R id=5 data=0xDEADBEEF resp=00 last=1.
REQ-030 Write: AW id=3 addr=0x22 len=0, W data=0x12345678 strb=0011; gnt after 3 stall cycles -> mem_addr_o=0x20, be=0011, req held 4 cycles; B id=3 resp=00.
REQ-031 Simultaneous AR and AW after reset, twice -> read granted first, then write; second conflict grants read again after toggling twice.
REQ-032 AR len=3 -> 4 R beats resp=10 data=0, r_last_o only on 4th; mem_req_o never asserted.
REQ-033 AW len=1 with 2 W beats (last on 2nd) -> both W accepted, no mem_req_o, B resp=10; mem_err_i=1 on a len=0 write -> B resp=10.
REQ-034 Backpressure: r_ready_i=0 for 5 cycles -> r_valid_o and payload stable; rst_i pulse in MEM_WAIT -> all outputs 0, later rvalid ignored.

Source files
------------

// File: rtl/axi2core_if.sv
// rtl/axi2core_if.sv - AXI4 slave channels plus core-style memory initiator port for axi2core
interface axi2core_if #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10
);
    logic [AXI4_ID_WIDTH-1:0]      aw_id_i;
    logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i;
    logic [7:0]                    aw_len_i;
    logic [2:0]                    aw_size_i;
    logic [1:0]                    aw_burst_i;
    logic [AXI4_USER_WIDTH-1:0]    aw_user_i;
    logic                          aw_valid_i;
    logic                          aw_ready_o;

    logic [31:0]                   w_data_i;
    logic [3:0]                    w_strb_i;
    logic                          w_last_i;
    logic [AXI4_USER_WIDTH-1:0]    w_user_i;
    logic                          w_valid_i;
    logic                          w_ready_o;

    logic [AXI4_ID_WIDTH-1:0]      b_id_o;
    logic [1:0]                    b_resp_o;
    logic [AXI4_USER_WIDTH-1:0]    b_user_o;
    logic                          b_valid_o;
    logic                          b_ready_i;

    logic [AXI4_ID_WIDTH-1:0]      ar_id_i;
    logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_i;
    logic [7:0]                    ar_len_i;
    logic [2:0]                    ar_size_i;
    logic [1:0]                    ar_burst_i;
    logic [AXI4_USER_WIDTH-1:0]    ar_user_i;
    logic                          ar_valid_i;
    logic                          ar_ready_o;

    logic [AXI4_ID_WIDTH-1:0]      r_id_o;
    logic [31:0]                   r_data_o;
    logic [1:0]                    r_resp_o;
    logic                          r_last_o;
    logic [AXI4_USER_WIDTH-1:0]    r_user_o;
    logic                          r_valid_o;
    logic                          r_ready_i;

    logic                          mem_req_o;
    logic                          mem_gnt_i;
    logic [AXI4_ADDRESS_WIDTH-1:0] mem_addr_o;
    logic                          mem_we_o;
    logic [3:0]                    mem_be_o;
    logic [31:0]                   mem_wdata_o;
    logic                          mem_rvalid_i;
    logic [31:0]                   mem_rdata_i;
    logic                          mem_err_i;

    modport slave (
        input  aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_user_i, aw_valid_i,
        output aw_ready_o,
        input  w_data_i, w_strb_i, w_last_i, w_user_i, w_valid_i,
        output w_ready_o,
        output b_id_o, b_resp_o, b_user_o, b_valid_o,
        input  b_ready_i,
        input  ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_user_i, ar_valid_i,
        output ar_ready_o,
        output r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o, r_valid_o,
        input  r_ready_i,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    modport master (
        output aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_user_i, aw_valid_i,
        input  aw_ready_o,
        output w_data_i, w_strb_i, w_last_i, w_user_i, w_valid_i,
        input  w_ready_o,
        input  b_id_o, b_resp_o, b_user_o, b_valid_o,
        output b_ready_i,
        output ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_user_i, ar_valid_i,
        input  ar_ready_o,
        input  r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o, r_valid_o,
        output r_ready_i,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );
endinterface

// File: rtl/axi2core.sv
// rtl/axi2core.sv - single-beat AXI4 slave bridged onto a req/gnt core memory port
// One transaction in flight; bursts (len != 0) are answered with SLVERR without touching memory.
module axi2core #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10
) (
    input  logic      clk_i,
    input  logic      rst_i,
    axi2core_if.slave bus
);
    localparam int AW = AXI4_ADDRESS_WIDTH;
    localparam int IW = AXI4_ID_WIDTH;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_DRAIN, MEM_REQ, MEM_WAIT, B_RESP, R_RESP
    } state_t;

    state_t        state, state_nxt;
    logic          prio;
    logic [IW-1:0] id;
    logic [AW-1:2] addr_word;
    logic [7:0]    len;
    logic          is_write;
    logic          err_mode;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    logic [7:0]    beat;

    logic grant_rd, grant_wr, ar_hs, aw_hs, w_hs, last_beat;

    logic unused;
    assign unused = ^{bus.aw_size_i, bus.aw_burst_i, bus.aw_user_i, bus.aw_addr_i[1:0],
                      bus.w_user_i, bus.ar_size_i, bus.ar_burst_i, bus.ar_user_i,
                      bus.ar_addr_i[1:0]};

    // prio=0 favours reads on a simultaneous AR/AW; readies never both high
    always_comb begin
        grant_rd  = bus.ar_valid_i && (!bus.aw_valid_i || !prio);
        grant_wr  = bus.aw_valid_i && (!bus.ar_valid_i || prio);
        ar_hs     = (state == IDLE) && grant_rd;
        aw_hs     = (state == IDLE) && grant_wr;
        w_hs      = ((state == WR_DATA) || (state == WR_DRAIN)) && bus.w_valid_i;
        last_beat = !err_mode || (beat == len);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    state_nxt = (bus.ar_len_i == 8'd0) ? MEM_REQ : R_RESP;
                end else if (aw_hs) begin
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.w_valid_i) begin
                    if (len == 8'd0)         state_nxt = MEM_REQ;
                    else if (bus.w_last_i)   state_nxt = B_RESP;
                    else                     state_nxt = WR_DRAIN;
                end
            end
            WR_DRAIN: if (bus.w_valid_i && bus.w_last_i) state_nxt = B_RESP;
            MEM_REQ:  if (bus.mem_gnt_i) state_nxt = MEM_WAIT;
            MEM_WAIT: if (bus.mem_rvalid_i) state_nxt = is_write ? B_RESP : R_RESP;
            B_RESP:   if (bus.b_ready_i) state_nxt = IDLE;
            R_RESP:   if (bus.r_ready_i && last_beat) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio      <= 1'b0;
            id        <= '0;
            addr_word <= '0;
            len       <= '0;
            is_write  <= 1'b0;
            err_mode  <= 1'b0;
            wdata     <= '0;
            be        <= '0;
            rdata     <= '0;
            resp      <= '0;
            beat      <= '0;
        end else begin
            if (ar_hs) begin
                prio      <= 1'b1;
                id        <= bus.ar_id_i;
                addr_word <= bus.ar_addr_i[AW-1:2];
                len       <= bus.ar_len_i;
                is_write  <= 1'b0;
                err_mode  <= (bus.ar_len_i != 8'd0);
                resp      <= (bus.ar_len_i != 8'd0) ? 2'b10 : 2'b00;
                rdata     <= '0;
                beat      <= '0;
            end else if (aw_hs) begin
                prio      <= 1'b0;
                id        <= bus.aw_id_i;
                addr_word <= bus.aw_addr_i[AW-1:2];
                len       <= bus.aw_len_i;
                is_write  <= 1'b1;
                err_mode  <= 1'b0;
                resp      <= 2'b00;
                beat      <= '0;
            end
            if (w_hs && (state == WR_DATA)) begin
                wdata <= bus.w_data_i;
                be    <= bus.w_strb_i;
                if (len != 8'd0) begin
                    err_mode <= 1'b1;
                    resp     <= 2'b10;
                end
            end
            // rvalid outside MEM_WAIT is deliberately ignored
            if ((state == MEM_WAIT) && bus.mem_rvalid_i) begin
                rdata <= bus.mem_rdata_i;
                resp  <= bus.mem_err_i ? 2'b10 : 2'b00;
            end
            if ((state == R_RESP) && bus.r_ready_i && !last_beat) begin
                beat <= beat + 8'd1;
            end
        end
    end

    always_comb begin
        bus.aw_ready_o  = aw_hs;
        bus.ar_ready_o  = ar_hs;
        bus.w_ready_o   = (state == WR_DATA) || (state == WR_DRAIN);

        bus.mem_req_o   = (state == MEM_REQ);
        bus.mem_addr_o  = (state == MEM_REQ) ? {addr_word, 2'b00} : '0;
        bus.mem_we_o    = (state == MEM_REQ) && is_write;
        bus.mem_be_o    = (state == MEM_REQ) ? (is_write ? be : 4'hF) : 4'h0;
        bus.mem_wdata_o = ((state == MEM_REQ) && is_write) ? wdata : '0;

        bus.b_valid_o   = (state == B_RESP);
        bus.b_id_o      = (state == B_RESP) ? id : '0;
        bus.b_resp_o    = (state == B_RESP) ? resp : 2'b00;
        bus.b_user_o    = '0;

        bus.r_valid_o   = (state == R_RESP);
        bus.r_id_o      = (state == R_RESP) ? id : '0;
        bus.r_data_o    = ((state == R_RESP) && !err_mode) ? rdata : '0;
        bus.r_resp_o    = (state == R_RESP) ? resp : 2'b00;
        bus.r_last_o    = (state == R_RESP) && last_beat;
        bus.r_user_o    = '0;
    end
endmodule

// File: tb/tb_axi2core.sv
// tb/tb_axi2core.sv - scoreboard bench for axi2core with a req/gnt memory responder model
module tb_axi2core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi2core_if bus ();
    axi2core dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    typedef struct packed { logic [15:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct packed { logic [15:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } m_exp_t;

    r_exp_t exp_r[$];
    b_exp_t exp_b[$];
    m_exp_t exp_m[$];
    logic [31:0] mem [logic [31:0]];

    int n_checks = 0, n_pass = 0, cyc = 0;
    int gnt_delay = 0, stall = 0, ar_hs_cyc = 0, last_resp_cyc = 0;
    bit err_next = 0, hold_rsp = 0, spurious = 0, pend = 0, pend_err = 0;
    logic [31:0] pend_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic any_out();
        return |{bus.aw_ready_o, bus.w_ready_o, bus.b_valid_o, bus.b_id_o, bus.b_resp_o, bus.b_user_o,
                 bus.ar_ready_o, bus.r_valid_o, bus.r_id_o, bus.r_data_o, bus.r_resp_o, bus.r_last_o,
                 bus.r_user_o, bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o};
    endfunction

    // memory responder: grants after gnt_delay stall cycles, answers one cycle after the grant
    initial begin
        m_exp_t e;
        logic [31:0] cur;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; bus.mem_err_i = 0;
        forever begin
            @(negedge clk);
            bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; bus.mem_err_i = 0;
            if (pend && !hold_rsp) begin
                bus.mem_rvalid_i = 1; bus.mem_rdata_i = pend_data; bus.mem_err_i = pend_err; pend = 0;
            end else if (spurious) begin
                bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hBAD0_BAD0; spurious = 0;
            end
            if (bus.mem_req_o && !rst) begin
                if (exp_m.size() == 0) begin
                    check("mem_unexpected_req", 64'(bus.mem_req_o), 64'd0);
                end else begin
                    e = exp_m[0];
                    check("mem_addr", 64'(bus.mem_addr_o), 64'(e.addr));
                    check("mem_we", 64'(bus.mem_we_o), 64'(e.we));
                    check("mem_be", 64'(bus.mem_be_o), 64'(e.be));
                    if (e.we) check("mem_wdata", 64'(bus.mem_wdata_o), 64'(e.wdata));
                    if (stall < gnt_delay) begin
                        stall++;
                    end else begin
                        bus.mem_gnt_i = 1; stall = 0;
                        void'(exp_m.pop_front());
                        pend = 1; pend_err = err_next; err_next = 0;
                        pend_data = e.we ? 32'h0 : mem_rd(e.addr);
                        if (e.we) begin
                            cur = mem_rd(e.addr);
                            for (int b = 0; b < 4; b++) if (e.be[b]) cur[8*b +: 8] = e.wdata[8*b +: 8];
                            mem[e.addr] = cur;
                        end
                    end
                end
            end
        end
    end

    // response monitor: pops scoreboard on handshakes, checks payload stability under backpressure
    initial begin
        bit r_hold = 0, b_hold = 0;
        logic [63:0] r_prev = 0, b_prev = 0;
        r_exp_t re;
        b_exp_t be_;
        forever begin
            @(negedge clk);
            if (rst) begin
                r_hold = 0; b_hold = 0;
            end else begin
                if (r_hold) check("r_stable", {bus.r_valid_o, bus.r_id_o, bus.r_data_o, bus.r_resp_o, bus.r_last_o}, r_prev);
                if (b_hold) check("b_stable", 64'({bus.b_valid_o, bus.b_id_o, bus.b_resp_o}), b_prev);
                if (bus.r_valid_o && bus.r_ready_i) begin
                    last_resp_cyc = cyc;
                    if (exp_r.size() == 0) check("r_unexpected", 64'(bus.r_valid_o), 64'd0);
                    else begin
                        re = exp_r.pop_front();
                        check("r_id", 64'(bus.r_id_o), 64'(re.id));
                        check("r_data", 64'(bus.r_data_o), 64'(re.data));
                        check("r_resp", 64'(bus.r_resp_o), 64'(re.resp));
                        check("r_last", 64'(bus.r_last_o), 64'(re.last));
                    end
                end
                if (bus.b_valid_o && bus.b_ready_i) begin
                    last_resp_cyc = cyc;
                    if (exp_b.size() == 0) check("b_unexpected", 64'(bus.b_valid_o), 64'd0);
                    else begin
                        be_ = exp_b.pop_front();
                        check("b_id", 64'(bus.b_id_o), 64'(be_.id));
                        check("b_resp", 64'(bus.b_resp_o), 64'(be_.resp));
                    end
                end
                r_hold = bus.r_valid_o && !bus.r_ready_i;
                r_prev = {bus.r_valid_o, bus.r_id_o, bus.r_data_o, bus.r_resp_o, bus.r_last_o};
                b_hold = bus.b_valid_o && !bus.b_ready_i;
                b_prev = 64'({bus.b_valid_o, bus.b_id_o, bus.b_resp_o});
            end
        end
    end

    task automatic do_ar(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        m_exp_t m;
        r_exp_t r;
        @(posedge clk); #1;
        bus.ar_id_i = id; bus.ar_addr_i = addr; bus.ar_len_i = len;
        bus.ar_size_i = 3'd2; bus.ar_burst_i = 2'd1; bus.ar_user_i = 10'h3FF; bus.ar_valid_i = 1;
        forever begin
            @(negedge clk);
            if (bus.ar_ready_o) break;
            if (++n > 300) begin check("ar_timeout", 64'(bus.ar_ready_o), 64'd1); break; end
        end
        if (bus.ar_ready_o) begin
            ar_hs_cyc = cyc;
            if (len == 0) begin
                m.addr = addr & ~32'h3; m.we = 0; m.be = 4'hF; m.wdata = 0;
                exp_m.push_back(m);
                r.id = id; r.data = mem_rd(addr & ~32'h3); r.resp = 2'b00; r.last = 1;
                exp_r.push_back(r);
            end else begin
                for (int i = 0; i <= int'(len); i++) begin
                    r.id = id; r.data = 0; r.resp = 2'b10; r.last = (i == int'(len));
                    exp_r.push_back(r);
                end
            end
        end
        @(posedge clk); #1;
        bus.ar_valid_i = 0;
    endtask

    task automatic do_aw(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input int beats, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        m_exp_t m;
        b_exp_t b;
        @(posedge clk); #1;
        bus.aw_id_i = id; bus.aw_addr_i = addr; bus.aw_len_i = len;
        bus.aw_size_i = 3'd2; bus.aw_burst_i = 2'd1; bus.aw_user_i = 10'h155; bus.aw_valid_i = 1;
        forever begin
            @(negedge clk);
            if (bus.aw_ready_o) break;
            if (++n > 300) begin check("aw_timeout", 64'(bus.aw_ready_o), 64'd1); break; end
        end
        if (len == 0) begin
            m.addr = addr & ~32'h3; m.we = 1; m.be = strb; m.wdata = data;
            exp_m.push_back(m);
            b.id = id; b.resp = err_next ? 2'b10 : 2'b00;
        end else begin
            b.id = id; b.resp = 2'b10;
        end
        exp_b.push_back(b);
        @(posedge clk); #1;
        bus.aw_valid_i = 0;
        for (int i = 0; i < beats; i++) begin
            bus.w_data_i = data + 32'(i); bus.w_strb_i = strb; bus.w_last_i = (i == beats - 1);
            bus.w_user_i = 10'h2AA; bus.w_valid_i = 1;
            n = 0;
            forever begin
                @(negedge clk);
                if (bus.w_ready_o) break;
                if (++n > 300) begin check("w_timeout", 64'(bus.w_ready_o), 64'd1); break; end
            end
            @(posedge clk); #1;
        end
        bus.w_valid_i = 0; bus.w_last_i = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_r.size() + exp_b.size() + exp_m.size()) != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        check(tag, 64'(exp_r.size() + exp_b.size() + exp_m.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic conflict(input logic [1:0] exp_readies, input logic [15:0] rid, input logic [15:0] wid);
        fork
            do_ar(rid, 32'h40, 8'd0);
            do_aw(wid, 32'h80 + 32'(wid), 8'd0, 1, 32'hA1A2_A300 + 32'(wid), 4'hF);
            begin @(posedge clk); @(negedge clk);
                check("arb_readies", 64'({bus.ar_ready_o, bus.aw_ready_o}), 64'(exp_readies)); end
        join
        drain("arb_drain");
    endtask

    initial begin
        int n;
        bus.aw_valid_i = 0; bus.w_valid_i = 0; bus.ar_valid_i = 0; bus.w_last_i = 0;
        bus.aw_id_i = 0; bus.aw_addr_i = 0; bus.aw_len_i = 0; bus.aw_size_i = 0; bus.aw_burst_i = 0; bus.aw_user_i = 0;
        bus.ar_id_i = 0; bus.ar_addr_i = 0; bus.ar_len_i = 0; bus.ar_size_i = 0; bus.ar_burst_i = 0; bus.ar_user_i = 0;
        bus.w_data_i = 0; bus.w_strb_i = 0; bus.w_user_i = 0;
        bus.b_ready_i = 1; bus.r_ready_i = 1;
        mem[32'h104] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(any_out()), 64'd0);
        @(posedge clk); #1 rst = 0;

        // arbitration: read first after reset, again after toggling twice, write first after a lone read
        conflict(2'b10, 16'd7, 16'd8);
        conflict(2'b10, 16'd17, 16'd18);
        do_ar(16'd20, 32'h60, 8'd0);
        drain("lone_read");
        conflict(2'b01, 16'd27, 16'd28);

        // single read with minimum latency
        do_ar(16'd5, 32'h104, 8'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.r_valid_o && n < 20);
        check("rd_latency", 64'(n), 64'd3);
        drain("read_104");

        // stalled write, then read it back through the memory model
        gnt_delay = 3;
        do_aw(16'd3, 32'h22, 8'd0, 1, 32'h1234_5678, 4'b0011);
        drain("write_22");
        gnt_delay = 0;
        do_ar(16'd30, 32'h20, 8'd0);
        drain("readback_20");

        // burst read and burst write errors, memory error on a write
        do_ar(16'd9, 32'h200, 8'd3);
        drain("burst_read");
        do_aw(16'd4, 32'h300, 8'd1, 2, 32'h5555_0000, 4'hF);
        drain("burst_write");
        err_next = 1;
        do_aw(16'd6, 32'h44, 8'd0, 1, 32'h0BAD_F00D, 4'hF);
        drain("mem_err_write");

        // R backpressure for 5 cycles
        bus.r_ready_i = 0;
        do_ar(16'd10, 32'h104, 8'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.r_valid_o && n < 20);
        repeat (5) @(negedge clk);
        check("r_held_valid", 64'(bus.r_valid_o), 64'd1);
        @(posedge clk); #1 bus.r_ready_i = 1;
        drain("backpressure");

        // back-to-back: second AR accepted the cycle after the R handshake
        do_ar(16'd11, 32'h8, 8'd0);
        do_ar(16'd12, 32'hC, 8'd0);
        check("b2b_gap", 64'(ar_hs_cyc - last_resp_cyc), 64'd1);
        drain("b2b");

        // reset while waiting on memory, then a stray rvalid
        hold_rsp = 1;
        do_ar(16'd13, 32'h10, 8'd0);
        @(posedge clk); #2 rst = 1;
        #1 check("midreset_outputs", 64'(any_out()), 64'd0);
        exp_r.delete(); pend = 0; hold_rsp = 0;
        @(posedge clk); #1 rst = 0; spurious = 1;
        n = 0;
        repeat (8) begin @(negedge clk); if (bus.r_valid_o || bus.b_valid_o || bus.mem_req_o) n++; end
        check("post_reset_quiet", 64'(n), 64'd0);

        do_ar(16'd14, 32'h104, 8'd0);
        drain("recovery_read");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
